// File: rtl/fp_exec_ctrl.sv
// Execute-stage sequencer for single-precision FP R-type ops.
// Accepts one op at a time, fires a one-cycle start pulse at the FPU,
// holds the pipeline for the op's fixed latency, then raises a one-cycle
// writeback strobe carrying the destination register.
module fp_exec_ctrl #(
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int RD_W    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fp_valid,
  input  logic [4:0]      funct5,
  input  logic [RD_W-1:0] rd,
  input  logic            flush,
  output logic            stall,
  output logic            fpu_start,
  output logic [1:0]      fpu_op,
  output logic            busy,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic            illegal
);

  localparam int CNT_W = $clog2(DIV_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             legalOp;
  logic             accept;
  logic [1:0]       opCode;
  logic [CNT_W-1:0] loadVal;

  // Only funct5 00000..00011 map onto the FPU; the low two bits are the op code.
  assign legalOp = (funct5[4:2] == 3'b000);
  assign opCode  = funct5[1:0];
  assign accept  = (state == IDLE) & fp_valid & legalOp & !flush;

  // The counter is preloaded with LAT-2 so that EXEC lasts LAT-1 cycles and
  // the writeback lands exactly LAT cycles after the accept cycle.
  always_comb begin
    loadVal = CNT_W'(ADD_LAT - 2);
    case (opCode)
      2'b10:   loadVal = CNT_W'(MUL_LAT - 2);
      2'b11:   loadVal = CNT_W'(DIV_LAT - 2);
      default: loadVal = CNT_W'(ADD_LAT - 2);
    endcase
  end

  // Stall covers the accept cycle and the whole EXEC phase; it is released in
  // WB so the held instruction advances and is never accepted a second time.
  assign stall    = accept | (state == EXEC);
  assign wb_valid = (state == WB) & !flush;

  // Sequencer: state, latency counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      fpu_start <= 1'b0;
      fpu_op    <= 2'b00;
      busy      <= 1'b0;
      wb_rd     <= '0;
      illegal   <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= EXEC;
            cnt       <= loadVal;
            fpu_start <= 1'b1;
            fpu_op    <= opCode;
            wb_rd     <= rd;
            busy      <= 1'b1;
          end else if (fp_valid && !flush && !legalOp) begin
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          // A redirect abandons the op; an issued start is not recalled and
          // the FPU result is simply never written back.
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state <= WB;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WB: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_exec_ctrl.sv
// Directed testbench for fp_exec_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge of the same cycle.
module tb_fp_exec_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       fp_valid;
  logic [4:0] funct5;
  logic [4:0] rd;
  logic       flush;
  logic       stall;
  logic       fpu_start;
  logic [1:0] fpu_op;
  logic       busy;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  fp_exec_ctrl #(
    .ADD_LAT(3),
    .MUL_LAT(4),
    .DIV_LAT(16),
    .RD_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fp_valid(fp_valid),
    .funct5(funct5),
    .rd(rd),
    .flush(flush),
    .stall(stall),
    .fpu_start(fpu_start),
    .fpu_op(fpu_op),
    .busy(busy),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] f5, input logic [4:0] r, input logic fl);
    fp_valid = v;
    funct5   = f5;
    rd       = r;
    flush    = fl;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({stall, fpu_start, fpu_op, busy, wb_valid, wb_rd, illegal} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0", {stall, fpu_start, fpu_op, busy, wb_valid, wb_rd, illegal});
    end
    reset = 1'b0;
    tick();
  endtask

  // FADD rd=7: stall T..T+2, start at T+1, writeback at T+3.
  task automatic test_fadd();
    drive(1'b1, 5'b00000, 5'd7, 1'b0);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (stall !== (i < 3)) begin errors++; $display("FAIL fadd_stall cyc %0d got %b required %b", i, stall, (i < 3)); end
      checks++;
      if (fpu_start !== (i == 1)) begin errors++; $display("FAIL fadd_start cyc %0d got %b required %b", i, fpu_start, (i == 1)); end
      checks++;
      if (wb_valid !== (i == 3)) begin errors++; $display("FAIL fadd_wbvalid cyc %0d got %b required %b", i, wb_valid, (i == 3)); end
      checks++;
      if (busy !== (i >= 1)) begin errors++; $display("FAIL fadd_busy cyc %0d got %b required %b", i, busy, (i >= 1)); end
      if (i == 1) begin
        checks++;
        if (fpu_op !== 2'b00) begin errors++; $display("FAIL fadd_op got %b required 00", fpu_op); end
      end
      if (i == 3) begin
        checks++;
        if (wb_rd !== 5'd7) begin errors++; $display("FAIL fadd_wbrd got %0d required 7", wb_rd); end
      end
      tick();
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL fadd_after busy %b wb %b required 0 0", busy, wb_valid); end
    tick();
  endtask

  // FDIV rd=31 held on the input through writeback: 16 stall cycles, no re-accept.
  task automatic test_fdiv();
    int stallCount = 0;
    drive(1'b1, 5'b00011, 5'd31, 1'b0);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (stall) stallCount++;
      checks++;
      if (wb_valid !== (i == 16)) begin errors++; $display("FAIL fdiv_wbvalid cyc %0d got %b required %b", i, wb_valid, (i == 16)); end
      if (i == 1) begin
        checks++;
        if (fpu_op !== 2'b11 || fpu_start !== 1'b1) begin errors++; $display("FAIL fdiv_issue op %b start %b required 11 1", fpu_op, fpu_start); end
      end
      if (i == 16) begin
        checks++;
        if (wb_rd !== 5'd31 || stall !== 1'b0) begin errors++; $display("FAIL fdiv_wb rd %0d stall %b required 31 0", wb_rd, stall); end
      end
      tick();
    end
    checks++;
    if (stallCount != 16) begin errors++; $display("FAIL fdiv_stallcount got %0d required 16", stallCount); end
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fpu_start !== 1'b0) begin errors++; $display("FAIL fdiv_reaccept busy %b start %b required 0 0", busy, fpu_start); end
    tick();
  endtask

  // FMUL accepted at T, flush at T+2: idle at T+3 and no writeback afterwards.
  task automatic test_flush_exec();
    int wbSeen = 0;
    drive(1'b1, 5'b00010, 5'd4, 1'b0);
    tick();
    tick();
    drive(1'b1, 5'b00010, 5'd4, 1'b1);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL flushexec_stall_t2 got %b required 1", stall); end
    tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flushexec_t3 stall %b busy %b required 0 0", stall, busy); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wb_valid) wbSeen++;
      tick();
    end
    checks++;
    if (wbSeen != 0) begin errors++; $display("FAIL flushexec_nowb got %0d strobes required 0", wbSeen); end
  endtask

  // Flush arriving in the WB cycle masks the strobe.
  task automatic test_flush_wb();
    drive(1'b1, 5'b00000, 5'd12, 1'b0);
    tick();
    tick();
    tick();
    drive(1'b1, 5'b00000, 5'd12, 1'b1);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL flushwb_wbvalid got %b required 0", wb_valid); end
    tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flushwb_busy got %b required 0", busy); end
    tick();
  endtask

  // Unsupported funct5: illegal pulse next cycle, nothing started; flush suppresses it.
  task automatic test_illegal();
    drive(1'b1, 5'b00100, 5'd3, 1'b0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL illegal_stall got %b required 0", stall); end
    tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if ({illegal, fpu_start, busy, stall} !== 4'b1000) begin errors++; $display("FAIL illegal_pulse got %b required 1000", {illegal, fpu_start, busy, stall}); end
    tick();
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_onecycle got %b required 0", illegal); end
    drive(1'b1, 5'b00100, 5'd3, 1'b1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_flushed got %b required 0", illegal); end
    drive(1'b1, 5'b00000, 5'd5, 1'b1);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL idleflush_stall got %b required 0", stall); end
    tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (fpu_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idleflush_accept start %b busy %b required 0 0", fpu_start, busy); end
    tick();
  endtask

  // FSUB then FMUL: second op accepted the cycle after the first writeback.
  task automatic test_back_to_back();
    drive(1'b1, 5'b00001, 5'd3, 1'b0);
    for (int i = 0; i <= 8; i++) begin
      if (i == 4) drive(1'b1, 5'b00010, 5'd9, 1'b0);
      @(negedge clk);
      checks++;
      if (wb_valid !== (i == 3 || i == 8)) begin errors++; $display("FAIL b2b_wbvalid cyc %0d got %b required %b", i, wb_valid, (i == 3 || i == 8)); end
      checks++;
      if (fpu_start !== (i == 1 || i == 5)) begin errors++; $display("FAIL b2b_start cyc %0d got %b required %b", i, fpu_start, (i == 1 || i == 5)); end
      if (i == 1 && fpu_op !== 2'b01) begin errors++; $display("FAIL b2b_op1 got %b required 01", fpu_op); end
      if (i == 5 && fpu_op !== 2'b10) begin errors++; $display("FAIL b2b_op2 got %b required 10", fpu_op); end
      if (i == 3 && wb_rd !== 5'd3) begin errors++; $display("FAIL b2b_rd1 got %0d required 3", wb_rd); end
      if (i == 8 && wb_rd !== 5'd9) begin errors++; $display("FAIL b2b_rd2 got %0d required 9", wb_rd); end
      if (i == 1 || i == 3 || i == 5 || i == 8) checks++;
      tick();
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    tick();
  endtask

  // Reset at T+5 of an FDIV; then a fresh FADD completes normally.
  task automatic test_reset_mid();
    int wbSeen = 0;
    drive(1'b1, 5'b00011, 5'd20, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++;
    if ({stall, fpu_start, fpu_op, busy, wb_valid, wb_rd, illegal} !== 12'd0) begin
      errors++;
      $display("FAIL resetmid_outputs got %b required 0", {stall, fpu_start, fpu_op, busy, wb_valid, wb_rd, illegal});
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (wb_valid) wbSeen++;
      tick();
    end
    checks++;
    if (wbSeen != 0) begin errors++; $display("FAIL resetmid_nowb got %0d strobes required 0", wbSeen); end
    drive(1'b1, 5'b00000, 5'd2, 1'b0);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== (i == 3)) begin errors++; $display("FAIL resetmid_fadd cyc %0d got %b required %b", i, wb_valid, (i == 3)); end
      if (i == 3) begin
        checks++;
        if (wb_rd !== 5'd2) begin errors++; $display("FAIL resetmid_rd got %0d required 2", wb_rd); end
      end
      tick();
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fdiv();
    test_flush_exec();
    test_flush_wb();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
